cache_ctrl_param: RTL and testbench

Parametrised write-back, write-allocate controller for a direct-mapped cache, sitting between the system request port, the cache tag/data array and a fixed-latency pipelined main memory. It generalises line size, address split and memory latency. It overlaps line fill with memory latency, and it detects illegal requests. An optional statistics block is available through a compile-time macro.

---
 rtl/cache_ctrl_param_if.sv | 62 ++++++
 rtl/cache_ctrl_param.sv | 197 +++++++++++++++++++
 tb/tb_cache_ctrl_param.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_param_if.sv
// Request/cache/memory bundle for cache_ctrl_param.
// master: controller view; slave: system, tag/data array and memory view.
interface cache_ctrl_param_if #(
  parameter int TAG_W   = 5,
  parameter int INDEX_W = 8,
  parameter int OFF_W   = 3
);
  logic               Rd;
  logic               Wr;
  logic [15:0]        Addr;
  logic [15:0]        DataIn;
  logic               hit;
  logic               dirty;
  logic               valid;
  logic [TAG_W-1:0]   tag_out;
  logic [15:0]        DataOut_cache;
  logic [15:0]        DataOut_mem;
  logic               enable_ct;
  logic               cmp_ct;
  logic               wr_cache;
  logic               valid_in_ct;
  logic [INDEX_W-1:0] index_cache;
  logic [OFF_W-1:0]   offset_cache;
  logic [TAG_W-1:0]   tag_cache;
  logic [15:0]        DataIn_ct;
  logic [15:0]        Addr_mem;
  logic [15:0]        DataIn_mem;
  logic               wr_mem;
  logic               rd_mem;
  logic               Done;
  logic               CacheHit;
  logic               Stall_sys;
  logic               err;
  logic [15:0]        hit_cnt;
  logic [15:0]        miss_cnt;

  modport master (
    input  Rd, Wr, Addr, DataIn,
    input  hit, dirty, valid, tag_out,
    input  DataOut_cache, DataOut_mem,
    output enable_ct, cmp_ct, wr_cache,
    output valid_in_ct, index_cache,
    output offset_cache, tag_cache, DataIn_ct,
    output Addr_mem, DataIn_mem,
    output wr_mem, rd_mem,
    output Done, CacheHit, Stall_sys, err,
    output hit_cnt, miss_cnt
  );

  modport slave (
    output Rd, Wr, Addr, DataIn,
    output hit, dirty, valid, tag_out,
    output DataOut_cache, DataOut_mem,
    input  enable_ct, cmp_ct, wr_cache,
    input  valid_in_ct, index_cache,
    input  offset_cache, tag_cache, DataIn_ct,
    input  Addr_mem, DataIn_mem,
    input  wr_mem, rd_mem,
    input  Done, CacheHit, Stall_sys, err,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl_param.sv
// Write-back, write-allocate direct-mapped cache controller with
// overlapped line fill over a fixed-latency pipelined memory.
// Ports: clk, rst (sync, active-high), bus (cache_ctrl_param_if.master):
//   system Rd/Wr/Addr/DataIn -> Done/CacheHit/Stall_sys/err,
//   tag/data array controls, memory rd_mem/wr_mem/Addr_mem/DataIn_mem.
// Optional hit/miss counters: define CACHE_STATS_EN.
module cache_ctrl_param #(
  parameter int TAG_W      = 5,
  parameter int INDEX_W    = 8,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 2
) (
  input logic                clk,
  input logic                rst,
  cache_ctrl_param_if.master bus
);
  localparam int OFF_W  = $clog2(LINE_WORDS) + 1;
  localparam int W_W    = OFF_W - 1;
  localparam int FILL_N = LINE_WORDS + MEM_LAT;
  localparam int CNT_W  = $clog2(FILL_N);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COMPARE,
    S_HIT,
    S_WB,
    S_FILL,
    S_RETRY,
    S_ERR
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cyc;
  logic               r_wr;

  logic [TAG_W-1:0]   w_tag;
  logic [INDEX_W-1:0] w_index;
  logic [OFF_W-1:0]   w_off;
  logic [W_W-1:0]     w_i;
  logic [W_W-1:0]     w_j;
  logic               w_req;
  logic               w_last_wb;
  logic               w_last_fill;
  logic               w_issue;
  logic               w_capture;

  assign w_tag   = bus.Addr[15 -: TAG_W];
  assign w_index = bus.Addr[15-TAG_W -: INDEX_W];
  assign w_off   = bus.Addr[OFF_W-1:0];

  // One cycle counter serves WB word, fill issue (i) and capture (j).
  assign w_i = r_cyc[W_W-1:0];
  assign w_j = W_W'(r_cyc - CNT_W'(MEM_LAT));

  assign w_req       = bus.Rd | bus.Wr;
  assign w_last_wb   = (r_cyc == CNT_W'(LINE_WORDS - 1));
  assign w_last_fill = (r_cyc == CNT_W'(FILL_N - 1));
  assign w_issue     = (r_cyc < CNT_W'(LINE_WORDS));
  assign w_capture   = (r_cyc >= CNT_W'(MEM_LAT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cyc   <= '0;
      r_wr    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state != w_next)
        r_cyc <= '0;
      else if (r_state == S_WB || r_state == S_FILL)
        r_cyc <= r_cyc + 1'b1;
      if (r_state == S_COMPARE)
        r_wr <= bus.Wr;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.Rd && bus.Wr)
          w_next = S_ERR;
        else if (w_req && bus.Addr[0])
          w_next = S_ERR;
        else if (w_req)
          w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (bus.hit && bus.valid)
          w_next = S_HIT;
        else if (bus.valid && bus.dirty)
          w_next = S_WB;
        else
          w_next = S_FILL;
      end
      S_WB: begin
        if (w_last_wb)
          w_next = S_FILL;
      end
      S_FILL: begin
        if (w_last_fill)
          w_next = S_RETRY;
      end
      S_HIT,
      S_RETRY,
      S_ERR: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    bus.enable_ct    = 1'b0;
    bus.cmp_ct       = 1'b0;
    bus.wr_cache     = 1'b0;
    bus.valid_in_ct  = 1'b0;
    bus.index_cache  = w_index;
    bus.offset_cache = w_off;
    bus.tag_cache    = w_tag;
    bus.DataIn_ct    = bus.DataIn;
    bus.Addr_mem     = '0;
    bus.DataIn_mem   = '0;
    bus.wr_mem       = 1'b0;
    bus.rd_mem       = 1'b0;
    bus.Done         = 1'b0;
    bus.CacheHit     = 1'b0;
    bus.Stall_sys    = 1'b1;
    bus.err          = 1'b0;
    unique case (r_state)
      S_IDLE: bus.Stall_sys = 1'b0;
      S_ERR: begin
        bus.Done = 1'b1;
        bus.err  = 1'b1;
      end
      S_COMPARE: begin
        bus.enable_ct = 1'b1;
        bus.cmp_ct    = 1'b1;
        bus.wr_cache  = bus.Wr;
      end
      S_HIT: begin
        bus.Done     = 1'b1;
        bus.CacheHit = 1'b1;
      end
      S_WB: begin
        bus.enable_ct    = 1'b1;
        bus.offset_cache = {w_i, 1'b0};
        bus.wr_mem       = 1'b1;
        bus.Addr_mem     = {bus.tag_out, w_index, w_i, 1'b0};
        bus.DataIn_mem   = bus.DataOut_cache;
      end
      S_FILL: begin
        // Issue and capture windows overlap by LINE_WORDS-MEM_LAT cycles.
        if (w_issue) begin
          bus.rd_mem   = 1'b1;
          bus.Addr_mem = {w_tag, w_index, w_i, 1'b0};
        end
        if (w_capture) begin
          bus.enable_ct    = 1'b1;
          bus.wr_cache     = 1'b1;
          bus.valid_in_ct  = 1'b1;
          bus.offset_cache = {w_j, 1'b0};
          bus.DataIn_ct    = bus.DataOut_mem;
        end
      end
      S_RETRY: begin
        bus.enable_ct = 1'b1;
        bus.cmp_ct    = 1'b1;
        bus.wr_cache  = r_wr;
        bus.Done      = 1'b1;
      end
      default: bus.Stall_sys = 1'b1;
    endcase
  end

`ifdef CACHE_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (r_state == S_HIT && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'd1;
      if (r_state == S_RETRY && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  assign bus.hit_cnt  = r_hit_cnt;
  assign bus.miss_cnt = r_miss_cnt;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_cache_ctrl_param.sv
// Bench for cache_ctrl_param: tag/data array and pipelined memory
// models, request and memory-op scoreboards.
module tb_cache_ctrl_param;
  localparam int TAG_W   = 5;
  localparam int INDEX_W = 8;
  localparam int LW      = 4;
  localparam int ML      = 2;
  localparam int OFF_W   = $clog2(LW) + 1;
  localparam int W_W     = OFF_W - 1;
  localparam int LINES   = 1 << INDEX_W;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  cache_ctrl_param_if #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W), .OFF_W(OFF_W)
  ) bus ();

  cache_ctrl_param #(
    .TAG_W(TAG_W), .INDEX_W(INDEX_W),
    .LINE_WORDS(LW), .MEM_LAT(ML)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [TAG_W-1:0] c_tag [LINES];
  logic             c_val [LINES];
  logic             c_dty [LINES];
  logic [15:0]      c_dat [LINES][LW];

  always_comb begin
    bus.tag_out       = c_tag[bus.index_cache];
    bus.valid         = c_val[bus.index_cache];
    bus.dirty         = c_dty[bus.index_cache];
    bus.hit           = (c_tag[bus.index_cache] == bus.tag_cache);
    bus.DataOut_cache =
      c_dat[bus.index_cache][bus.offset_cache[OFF_W-1:1]];
  end

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < LINES; i++) begin
        c_val[i] <= 1'b0;
        c_dty[i] <= 1'b0;
      end
    end else if (bus.enable_ct && bus.wr_cache) begin
      if (bus.cmp_ct) begin
        if (bus.hit && bus.valid) begin
          c_dat[bus.index_cache][bus.offset_cache[OFF_W-1:1]]
            <= bus.DataIn_ct;
          c_dty[bus.index_cache] <= 1'b1;
        end
      end else begin
        c_dat[bus.index_cache][bus.offset_cache[OFF_W-1:1]]
          <= bus.DataIn_ct;
        c_val[bus.index_cache] <= bus.valid_in_ct;
        c_tag[bus.index_cache] <= bus.tag_cache;
        c_dty[bus.index_cache] <= 1'b0;
      end
    end
  end

  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 16'hA5C3;
  endfunction

  logic [15:0] p_dat [ML];
  always @(posedge clk) begin
    p_dat[0] <= bus.rd_mem ? mem_rd(bus.Addr_mem) : 16'h0;
    for (int k = 1; k < ML; k++) p_dat[k] <= p_dat[k-1];
  end
  assign bus.DataOut_mem = p_dat[ML-1];

  typedef struct {
    int   lat;
    logic hit;
    logic err;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } mop_t;

  exp_t rq [$];
  mop_t mq [$];
  int exp_hits = 0;
  int exp_miss = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (bus.wr_mem || bus.rd_mem) begin
        if (mq.size() == 0) begin
          chk("mem_unexp", {bus.wr_mem, bus.rd_mem, bus.Addr_mem}, 0);
        end else begin
          mop_t m;
          m = mq.pop_front();
          chk("mem_op", {bus.wr_mem, bus.rd_mem, bus.Addr_mem},
              {m.wr, ~m.wr, m.a});
          if (m.wr) chk("wb_data", bus.DataIn_mem, m.d);
        end
        if (bus.wr_mem) mem[bus.Addr_mem] = bus.DataIn_mem;
      end
    end
  end

  task automatic request(input logic rd, input logic wr,
                         input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    exp_t g;
    logic [TAG_W-1:0]   t;
    logic [INDEX_W-1:0] ix;
    int cyc;
    t  = a[15 -: TAG_W];
    ix = a[15-TAG_W -: INDEX_W];
    e.hit = 1'b0;
    e.err = 1'b0;
    if ((rd && wr) || a[0]) begin
      e.lat = 1;
      e.err = 1'b1;
    end else if (c_val[ix] && c_tag[ix] == t) begin
      e.lat = 2;
      e.hit = 1'b1;
      exp_hits++;
    end else begin
      e.lat = 2 + LW + ML;
      if (c_val[ix] && c_dty[ix]) begin
        e.lat = 2 + 2 * LW + ML;
        for (int w = 0; w < LW; w++)
          mq.push_back('{1'b1, {c_tag[ix], ix, W_W'(w), 1'b0},
                         c_dat[ix][w]});
      end
      for (int w = 0; w < LW; w++)
        mq.push_back('{1'b0, {t, ix, W_W'(w), 1'b0}, 16'h0});
      exp_miss++;
    end
    rq.push_back(e);
    bus.Rd     = rd;
    bus.Wr     = wr;
    bus.Addr   = a;
    bus.DataIn = d;
    cyc = 0;
    while (!bus.Done && cyc < 64) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    g = rq.pop_front();
    chk("latency", cyc, g.lat);
    chk("cache_hit", bus.CacheHit, g.hit);
    chk("err", bus.err, g.err);
    chk("stall_busy", bus.Stall_sys, 1);
    if (g.err)
      chk("err_strobes",
          {bus.enable_ct, bus.wr_cache, bus.rd_mem, bus.wr_mem}, 0);
    if (!g.err && !g.hit && wr)
      chk("retry_merge", {bus.wr_cache, bus.DataIn_ct}, {1'b1, d});
    bus.Rd = 1'b0;
    bus.Wr = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_done", {bus.Stall_sys, bus.Done}, 0);
  endtask

  initial begin
    rst        = 1'b1;
    clr        = 1'b1;
    bus.Rd     = 1'b0;
    bus.Wr     = 1'b0;
    bus.Addr   = 16'h0;
    bus.DataIn = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_status",
        {bus.Done, bus.CacheHit, bus.err, bus.Stall_sys}, 0);
    chk("rst_strobes",
        {bus.enable_ct, bus.cmp_ct, bus.wr_cache, bus.valid_in_ct,
         bus.rd_mem, bus.wr_mem}, 0);
    chk("rst_cnt", {bus.hit_cnt, bus.miss_cnt}, 0);
    clr = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    request(1'b1, 1'b0, 16'h1234, 16'h0);
    for (int w = 0; w < LW; w++) begin
      logic [15:0] fa;
      fa = {5'd2, 8'h46, W_W'(w), 1'b0};
      chk("fill_word", c_dat[8'h46][w], mem_rd(fa));
    end
    request(1'b1, 1'b0, 16'h1234, 16'h0);
    request(1'b0, 1'b1, 16'h1234, 16'hBEEF);
    chk("hit_wr_data", c_dat[8'h46][2], 16'hBEEF);

    request(1'b0, 1'b1, 16'h2238, 16'hCAFE);
    chk("miss_wr_data", {c_dty[8'h47], c_dat[8'h47][0]},
        {1'b1, 16'hCAFE});
    chk("miss_wr_nbr", c_dat[8'h47][1], 16'h223A ^ 16'hA5C3);
    request(1'b1, 1'b0, 16'h2238, 16'h0);

    request(1'b1, 1'b0, 16'h9234, 16'h0);
    chk("wb_mem", mem_rd(16'h1234), 16'hBEEF);
    chk("new_tag", {c_tag[8'h46], c_dty[8'h46]}, {5'h12, 1'b0});
    request(1'b1, 1'b0, 16'h9234, 16'h0);

    request(1'b1, 1'b1, 16'h1234, 16'h0);
    request(1'b1, 1'b0, 16'h0001, 16'h0);
    request(1'b0, 1'b1, 16'h2239, 16'h1111);

`ifdef CACHE_STATS_EN
    chk("hit_cnt", bus.hit_cnt, exp_hits);
    chk("miss_cnt", bus.miss_cnt, exp_miss);
`else
    chk("hit_cnt_off", bus.hit_cnt, 0);
    chk("miss_cnt_off", bus.miss_cnt, 0);
`endif

    bus.Rd   = 1'b1;
    bus.Addr = 16'h0280;
    for (int w = 0; w < LW; w++)
      mq.push_back('{1'b0, {5'd0, 8'h50, W_W'(w), 1'b0}, 16'h0});
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    chk("fill3_strobes", {bus.rd_mem, bus.wr_cache}, 2'b11);
    rst    = 1'b1;
    bus.Rd = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_state", {bus.Stall_sys, bus.Done}, 0);
    chk("abort_strb", {bus.rd_mem, bus.wr_cache, bus.enable_ct}, 0);
    chk("abort_cnt", {bus.hit_cnt, bus.miss_cnt}, 0);
    rst      = 1'b0;
    exp_hits = 0;
    exp_miss = 0;
    @(posedge clk);
    #1;

    request(1'b1, 1'b0, 16'h0300, 16'h0);
    request(1'b1, 1'b0, 16'h0300, 16'h0);

`ifdef CACHE_STATS_EN
    chk("hit_cnt2", bus.hit_cnt, exp_hits);
    chk("miss_cnt2", bus.miss_cnt, exp_miss);
`endif
    repeat (ML + 1) @(posedge clk);
    #1;
    chk("mq_left", mq.size(), 0);
    chk("rq_left", rq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
